// File: rtl/sram16_target.sv
// sram16_target: 16-bit bridge-bus responder backed by an inferred RAM.
// Programmable wait states between request acceptance and completion.
module sram16_target #(
   parameter int ADDR_BITS   = 10,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] b_addr,
   input  logic [15:0] b_wdata,
   output logic [15:0] b_rdata,
   input  logic        b_wr_en,
   input  logic [1:0]  b_bytesel,
   output logic        b_compl
);

   localparam int DEPTH = 2 ** ADDR_BITS;
   localparam logic [3:0] WS_LOAD =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
   localparam bit HAS_WAIT = (WAIT_STATES > 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_ACCESS,
      S_RESP
   } state_t;

   typedef struct packed {
      logic [ADDR_BITS-1:0] idx;
      logic [15:0]          wdata;
      logic [1:0]           be;
      logic                 wr;
   } req_t;

   state_t state, state_nxt;
   logic [3:0] cnt, cnt_nxt;
   logic accept;
   req_t req;

   logic [15:0] mem [DEPTH];

   logic unused_addr;
   assign unused_addr = ^{b_addr[31:ADDR_BITS+1], b_addr[0]};

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (|b_bytesel) begin
               accept    = 1'b1;
               cnt_nxt   = WS_LOAD;
               state_nxt = HAS_WAIT ? S_WAIT : S_ACCESS;
            end
         end
         S_WAIT: begin
            if (cnt == 4'd0) state_nxt = S_ACCESS;
            else             cnt_nxt   = cnt - 4'd1;
         end
         S_ACCESS: state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= 4'd0;
         b_compl <= 1'b0;
         b_rdata <= 16'h0000;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         b_compl <= (state == S_ACCESS);
         if (state == S_ACCESS && !req.wr)
            b_rdata <= mem[req.idx];
         else
            b_rdata <= 16'h0000;
      end
   end

   // Latched copy is authoritative once the request is accepted.
   always_ff @(posedge clk) begin
      if (accept) begin
         req.idx   <= b_addr[ADDR_BITS:1];
         req.wdata <= b_wdata;
         req.be    <= b_bytesel;
         req.wr    <= b_wr_en;
      end
   end

   // Commit happens on the edge entering RESP; reset on that edge aborts it.
   always_ff @(posedge clk) begin
      if (!rst && state == S_ACCESS && req.wr) begin
         if (req.be[0]) mem[req.idx][7:0]  <= req.wdata[7:0];
         if (req.be[1]) mem[req.idx][15:8] <= req.wdata[15:8];
      end
   end

endmodule

// File: tb/tb_sram16_target.sv
// Directed self-checking bench for sram16_target.
// Three instances cover WAIT_STATES = 0, 2 and 5.
module tb_sram16_target;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] addr;
   logic [15:0] wdata;
   logic        wr_en;
   logic [1:0]  be0, be2, be5;
   logic [15:0] rd0, rd2, rd5;
   logic        c0, c2, c5;

   int checks = 0;
   int errors = 0;
   int sel = 2;
   int pulses2 = 0;
   int dbl2 = 0;
   logic c2_prev = 1'b0;

   logic        cmpl;
   logic [15:0] rdat;

   sram16_target #(.ADDR_BITS(10), .WAIT_STATES(0)) u_d0 (
      .clk(clk), .rst(rst), .b_addr(addr), .b_wdata(wdata),
      .b_rdata(rd0), .b_wr_en(wr_en), .b_bytesel(be0), .b_compl(c0)
   );
   sram16_target #(.ADDR_BITS(10), .WAIT_STATES(2)) u_d2 (
      .clk(clk), .rst(rst), .b_addr(addr), .b_wdata(wdata),
      .b_rdata(rd2), .b_wr_en(wr_en), .b_bytesel(be2), .b_compl(c2)
   );
   sram16_target #(.ADDR_BITS(10), .WAIT_STATES(5)) u_d5 (
      .clk(clk), .rst(rst), .b_addr(addr), .b_wdata(wdata),
      .b_rdata(rd5), .b_wr_en(wr_en), .b_bytesel(be5), .b_compl(c5)
   );

   always_comb begin
      cmpl = c2;
      rdat = rd2;
      if (sel == 0) begin
         cmpl = c0;
         rdat = rd0;
      end else if (sel == 5) begin
         cmpl = c5;
         rdat = rd5;
      end
   end

   always @(posedge clk) begin
      if (c2) pulses2++;
      if (c2 && c2_prev) dbl2++;
      c2_prev = c2;
   end

   task automatic set_be(input logic [1:0] v);
      be0 = 2'b00;
      be2 = 2'b00;
      be5 = 2'b00;
      case (sel)
         0:       be0 = v;
         5:       be5 = v;
         default: be2 = v;
      endcase
   endtask

   // Drives one request; scrambles the bus after acceptance.
   task automatic bus_op(
      input  logic [31:0] a,
      input  logic [15:0] wd,
      input  logic        wr,
      input  logic [1:0]  be,
      output logic [15:0] rd,
      output int          lat,
      output int          leak
   );
      addr  = a;
      wdata = wd;
      wr_en = wr;
      set_be(be);
      @(posedge clk);
      #1;
      set_be(2'b00);
      addr  = 32'hFFFF_FFFF;
      wdata = ~wd;
      wr_en = ~wr;
      lat   = 1;
      leak  = 0;
      while (!cmpl && lat < 40) begin
         if (rdat !== 16'h0000) leak++;
         @(posedge clk);
         #1;
         lat++;
      end
      rd = rdat;
      @(posedge clk);
      #1;
      if (rdat !== 16'h0000 || cmpl !== 1'b0) leak++;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      set_be(2'b00);
      addr  = 32'h0;
      wdata = 16'h0;
      wr_en = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if ({c0, c2, c5} !== 3'b000) begin
         errors++;
         $display("FAIL reset_compl got %b want 000", {c0, c2, c5});
      end
      checks++;
      if (rd2 !== 16'h0000 || rd0 !== 16'h0000 || rd5 !== 16'h0000) begin
         errors++;
         $display("FAIL reset_rdata got %h/%h/%h want 0", rd0, rd2, rd5);
      end
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_write_read;
      logic [15:0] rd;
      int lat, leak;
      sel = 2;
      bus_op(32'h10, 16'hBEEF, 1'b1, 2'b11, rd, lat, leak);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL wr_latency got %0d want 4", lat);
      end
      checks++;
      if (rd !== 16'h0000 || leak !== 0) begin
         errors++;
         $display("FAIL wr_rdata got %h leak %0d want 0000 leak 0", rd, leak);
      end
      bus_op(32'h10, 16'h0000, 1'b0, 2'b11, rd, lat, leak);
      checks++;
      if (lat !== 4) begin
         errors++;
         $display("FAIL rd_latency got %0d want 4", lat);
      end
      checks++;
      if (rd !== 16'hBEEF || leak !== 0) begin
         errors++;
         $display("FAIL rd_data got %h leak %0d want beef leak 0", rd, leak);
      end
   endtask

   task automatic test_byte_lanes;
      logic [15:0] rd;
      int lat, leak;
      sel = 2;
      bus_op(32'h20, 16'h1234, 1'b1, 2'b11, rd, lat, leak);
      bus_op(32'h20, 16'hAB00, 1'b1, 2'b10, rd, lat, leak);
      bus_op(32'h20, 16'h0000, 1'b0, 2'b01, rd, lat, leak);
      checks++;
      if (rd !== 16'hAB34) begin
         errors++;
         $display("FAIL lane_hi got %h want ab34", rd);
      end
      bus_op(32'h20, 16'h00CD, 1'b1, 2'b01, rd, lat, leak);
      bus_op(32'h20, 16'h0000, 1'b0, 2'b10, rd, lat, leak);
      checks++;
      if (rd !== 16'hABCD) begin
         errors++;
         $display("FAIL lane_lo got %h want abcd", rd);
      end
   endtask

   // Emulates the 32-to-16 bridge HWORD1 -> HWORD2 sequence.
   task automatic test_back_to_back;
      logic [15:0] lo, hi, rd;
      int lat1, lat2, leak;
      int p0;
      sel = 2;
      p0 = pulses2;
      bus_op(32'h40, 16'hF00D, 1'b1, 2'b11, rd, lat1, leak);
      bus_op(32'h42, 16'hCAFE, 1'b1, 2'b11, rd, lat2, leak);
      checks++;
      if (lat1 !== 4 || lat2 !== 4) begin
         errors++;
         $display("FAIL b2b_wr_lat got %0d,%0d want 4,4", lat1, lat2);
      end
      checks++;
      if (pulses2 - p0 !== 2) begin
         errors++;
         $display("FAIL b2b_wr_pulses got %0d want 2", pulses2 - p0);
      end
      bus_op(32'h40, 16'h0000, 1'b0, 2'b11, lo, lat1, leak);
      bus_op(32'h42, 16'h0000, 1'b0, 2'b11, hi, lat2, leak);
      checks++;
      if ({hi, lo} !== 32'hCAFEF00D) begin
         errors++;
         $display("FAIL b2b_word got %h want cafef00d", {hi, lo});
      end
      checks++;
      if (pulses2 - p0 !== 4) begin
         errors++;
         $display("FAIL b2b_total_pulses got %0d want 4", pulses2 - p0);
      end
   endtask

   task automatic test_latency;
      logic [15:0] rd;
      int lat, leak;
      sel = 0;
      bus_op(32'h60, 16'h1357, 1'b1, 2'b11, rd, lat, leak);
      checks++;
      if (lat !== 2) begin
         errors++;
         $display("FAIL ws0_wr_lat got %0d want 2", lat);
      end
      bus_op(32'h60, 16'h0000, 1'b0, 2'b11, rd, lat, leak);
      checks++;
      if (lat !== 2 || rd !== 16'h1357) begin
         errors++;
         $display("FAIL ws0_rd got lat %0d data %h want 2 1357", lat, rd);
      end
      sel = 5;
      bus_op(32'h62, 16'h2468, 1'b1, 2'b11, rd, lat, leak);
      checks++;
      if (lat !== 7) begin
         errors++;
         $display("FAIL ws5_wr_lat got %0d want 7", lat);
      end
      bus_op(32'h62, 16'h0000, 1'b0, 2'b11, rd, lat, leak);
      checks++;
      if (lat !== 7 || rd !== 16'h2468 || leak !== 0) begin
         errors++;
         $display("FAIL ws5_rd got lat %0d data %h leak %0d want 7 2468 0",
                  lat, rd, leak);
      end
      sel = 2;
   endtask

   task automatic test_reset_midop;
      logic [15:0] rd;
      int lat, leak, p0, seen;
      sel = 2;
      bus_op(32'h30, 16'h55AA, 1'b1, 2'b11, rd, lat, leak);
      p0 = pulses2;
      addr  = 32'h30;
      wdata = 16'h1111;
      wr_en = 1'b1;
      set_be(2'b11);
      @(posedge clk);
      #1;
      set_be(2'b00);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      checks++;
      if (c2 !== 1'b0 || rd2 !== 16'h0000) begin
         errors++;
         $display("FAIL midop_rst got compl %b rdata %h want 0 0000", c2, rd2);
      end
      seen = 0;
      repeat (6) begin
         @(posedge clk);
         #1;
         if (c2) seen++;
      end
      checks++;
      if (seen !== 0 || pulses2 !== p0) begin
         errors++;
         $display("FAIL midop_no_compl got %0d pulses want 0", seen);
      end
      // Reset while in ACCESS: the commit edge is suppressed.
      wdata = 16'h2222;
      set_be(2'b11);
      @(posedge clk);
      #1;
      set_be(2'b00);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus_op(32'h30, 16'h0000, 1'b0, 2'b11, rd, lat, leak);
      checks++;
      if (rd !== 16'h55AA) begin
         errors++;
         $display("FAIL midop_ram got %h want 55aa", rd);
      end
   endtask

   task automatic test_alias;
      logic [15:0] rd;
      int lat, leak;
      sel = 2;
      bus_op(32'h0802, 16'h7777, 1'b1, 2'b11, rd, lat, leak);
      bus_op(32'h0002, 16'h0000, 1'b0, 2'b11, rd, lat, leak);
      checks++;
      if (rd !== 16'h7777) begin
         errors++;
         $display("FAIL alias_hi got %h want 7777", rd);
      end
      bus_op(32'h0003, 16'h0000, 1'b0, 2'b11, rd, lat, leak);
      checks++;
      if (rd !== 16'h7777) begin
         errors++;
         $display("FAIL alias_bit0 got %h want 7777", rd);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_lanes();
      test_back_to_back();
      test_latency();
      test_reset_midop();
      test_alias();
      checks++;
      if (dbl2 !== 0) begin
         errors++;
         $display("FAIL compl_double got %0d want 0", dbl2);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sram16_target.md
Name: sram16_target

Overview:
- 16-bit memory responder for the 16-bit bridge bus (b_addr/b_wdata/b_rdata/b_wr_en/b_bytesel/b_compl).
- Services half-word read and write requests from the 32-to-16 bridge, or any 16-bit initiator, using an internal inferred RAM with programmable wait states.
- Used as on-chip boot/scratch RAM and as the bus-level stand-in for the SDRAM controller in bench and FPGA bring-up.

Parameters:
ADDR_BITS, 10, number of half-word index bits (RAM depth = 2**ADDR_BITS x 16).
WAIT_STATES, 2, extra cycles between request acceptance and completion (0..15).

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous reset, active-high.
b_addr  input  32  byte address; bit 0 ignored; index = b_addr[ADDR_BITS:1]; higher bits ignored (aliasing).
b_wdata  input  16  write data.
b_rdata  output  16  read data; valid only while b_compl is high.
b_wr_en  input  1  1 = write, 0 = read; sampled with the request.
b_bytesel  input  2  byte lanes ([0] = bits 7:0, [1] = bits 15:8); non-zero = request.
b_compl  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high, rst):
  - b_compl=0, b_rdata=0, state=IDLE, wait counter=0.
  - RAM contents are not cleared.
- Request:
  - In IDLE, |b_bytesel=1 at a rising edge accepts the request.
  - Latch index, wdata, bytesel and wr_en into internal registers. The initiator holds them, but the latched copy is authoritative.
- States:
  - IDLE: on request, go to WAIT when WAIT_STATES>0, else ACCESS. Load counter = WAIT_STATES-1.
  - WAIT: decrement counter; at 0 go to ACCESS. Bus inputs ignored.
  - ACCESS: go to RESP.
    - Write: update RAM byte lanes where the latched bytesel bit = 1; other lanes unchanged.
    - Read: register the full 16-bit RAM word into b_rdata, regardless of bytesel.
    - In both cases register b_compl=1.
  - RESP: b_compl=1 for exactly this cycle; go to IDLE. b_bytesel is ignored in RESP, because the initiator masks it to 0 while b_compl is high.
- b_rdata:
  - Holds read data only during RESP.
  - Zero in every other state and during write completion.
- Latency: request accepted at edge N -> b_compl high in cycle N+2+WAIT_STATES (edge-to-pulse), i.e. WAIT_STATES+2 cycles including ACCESS.
- Throughput:
  - A new request may be presented in the cycle after RESP (IDLE) and is accepted at that edge.
  - Minimum period is WAIT_STATES+3 cycles per access. The bridge's HWORD1->HWORD2 back-to-back sequence must work with no lost or duplicated access.
- Write commit point: the RAM is written at the edge entering RESP. Reset asserted before that edge means no RAM modification; after it, the write stands.
- Reset mid-operation (any state): return to IDLE next edge, b_compl=0, b_rdata=0, no completion issued for the aborted request.
- b_bytesel changing or dropping to 0 during WAIT/ACCESS: ignored; the latched request completes.
- Read-after-write to the same index in consecutive accesses returns the new data (no bypass needed, the write commits before the next request).
- Exactly one b_compl pulse per accepted request; never two consecutive high cycles.

Test Plan:
- Full write/read, WAIT_STATES=2:
  - Write b_addr=0x10, wdata=0xBEEF, bytesel=11 -> b_compl pulse 4 cycles after acceptance, b_rdata=0.
  - Read 0x10 -> b_rdata=0xBEEF in the b_compl cycle, 0 otherwise.
- Byte lanes:
  - Write 0x1234 to 0x20 with bytesel=11, then 0xAB00 with bytesel=10.
  - Read 0x20 -> 0xAB34. Then 0x00CD with bytesel=01 -> read 0xABCD.
- 32-bit via bridge:
  - Drive the 32-to-16 bridge with h_addr=0x40, h_wdata=0xCAFEF00D, bytesel=1111, write.
  - Then read -> h_rdata=0xCAFEF00D.
  - Exactly two target accesses at 0x40 and 0x42, each with one b_compl.
- Latency sweep:
  - WAIT_STATES=0 -> b_compl 2 cycles after acceptance. WAIT_STATES=5 -> 7 cycles.
  - Back-to-back requests accepted the cycle after each b_compl.
- Reset mid-op:
  - Pre-load 0x55AA at 0x30, start write 0x1111 to 0x30, assert rst during WAIT.
  - Expect b_compl=0 next cycle, and a later read of 0x30 returns 0x55AA.
- Aliasing/bit 0:
  - With ADDR_BITS=10, write 0x7777 to 0x0802 -> read 0x0002 returns 0x7777.
  - Read 0x0003 also returns 0x7777.
